// File: rtl/nn_parameters.sv
// Shared parameters for the sequential argmax output layer.
// Defaults match the final network layer (3 classes, 32-bit scores).
package nn_parameters;

  localparam int          NN_NUM_CLASSES   = 3;
  localparam int          NN_DATA_W        = 32;
  localparam int unsigned NN_REJECT_MARGIN = 0;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_e;

endpackage

// File: rtl/argmax_update.sv
// One step of the running argmax: folds a new score into (best, best_idx, second).
// Purely combinational; ties keep the earlier (lower) index.
module argmax_update #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 2
) (
  input  logic signed [DATA_W-1:0] best_i,
  input  logic        [IDX_W-1:0]  best_idx_i,
  input  logic signed [DATA_W-1:0] second_i,
  input  logic signed [DATA_W-1:0] score_i,
  input  logic        [IDX_W-1:0]  idx_i,
  output logic signed [DATA_W-1:0] best_o,
  output logic        [IDX_W-1:0]  best_idx_o,
  output logic signed [DATA_W-1:0] second_o
);

  // New winner demotes the old best to runner-up; otherwise only runner-up may move.
  always_comb begin
    best_o     = best_i;
    best_idx_o = best_idx_i;
    second_o   = second_i;
    if (score_i > best_i) begin
      best_o     = score_i;
      best_idx_o = idx_i;
      second_o   = best_i;
    end else if (score_i > second_i) begin
      second_o = score_i;
    end
  end

endmodule

// File: rtl/seq_argmax_layer.sv
// Sequential argmax over a stream of class scores, one class per beat.
// Emits winning class, its score and the margin over the runner-up.
// Optional: define SEQ_ARGMAX_REJECT_EN to report class NUM_CLASSES
// when the margin is below REJECT_MARGIN.
module seq_argmax_layer
  import nn_parameters::*;
#(
  parameter int          NUM_CLASSES   = NN_NUM_CLASSES,
  parameter int          DATA_W        = NN_DATA_W,
  parameter int unsigned REJECT_MARGIN = NN_REJECT_MARGIN,
  localparam int         IDX_W         = $clog2(NUM_CLASSES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_score,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [IDX_W-1:0]  out_class,
  output logic signed [DATA_W-1:0] out_score,
  output logic        [DATA_W-1:0] out_margin
);

  localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic        [IDX_W-1:0]  LAST = IDX_W'(NUM_CLASSES - 1);

  state_e                     state_q, state_d;
  logic        [IDX_W-1:0]    cnt_q, cnt_d;
  logic signed [DATA_W-1:0]   best_q, best_d;
  logic        [IDX_W-1:0]    best_idx_q, best_idx_d;
  logic signed [DATA_W-1:0]   second_q, second_d;
  logic        [IDX_W-1:0]    out_class_q, out_class_d;
  logic signed [DATA_W-1:0]   out_score_q, out_score_d;
  logic        [DATA_W-1:0]   out_margin_q, out_margin_d;

  logic signed [DATA_W-1:0]   ub_best, ub_second, upd_best, upd_second;
  logic        [IDX_W-1:0]    ub_idx, upd_idx, final_class;
  logic        [DATA_W-1:0]   margin_w;

  // Beat 0 starts from an empty tracker so stale frame state never leaks in.
  always_comb begin
    ub_best   = (cnt_q == '0) ? SMIN : best_q;
    ub_idx    = (cnt_q == '0) ? '0   : best_idx_q;
    ub_second = (cnt_q == '0) ? SMIN : second_q;
  end

  argmax_update #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_upd (
    .best_i     (ub_best),
    .best_idx_i (ub_idx),
    .second_i   (ub_second),
    .score_i    (in_score),
    .idx_i      (cnt_q),
    .best_o     (upd_best),
    .best_idx_o (upd_idx),
    .second_o   (upd_second)
  );

  // Margin taken in DATA_W+1 bits; best >= second so the low DATA_W bits are exact.
  always_comb begin
    margin_w = DATA_W'((DATA_W+1)'(upd_best) - (DATA_W+1)'(upd_second));
`ifdef SEQ_ARGMAX_REJECT_EN
    final_class = ({1'b0, margin_w} < (DATA_W+1)'(REJECT_MARGIN)) ? IDX_W'(NUM_CLASSES)
                                                                 : upd_idx;
`else
    final_class = upd_idx;
`endif
  end

  // FSM: accumulate beats in COLLECT, hold the result in EMIT until taken.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    best_d       = best_q;
    best_idx_d   = best_idx_q;
    second_d     = second_q;
    out_class_d  = out_class_q;
    out_score_d  = out_score_q;
    out_margin_d = out_margin_q;
    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          best_d     = upd_best;
          best_idx_d = upd_idx;
          second_d   = upd_second;
          if (cnt_q == LAST) begin
            cnt_d        = '0;
            state_d      = EMIT;
            out_class_d  = final_class;
            out_score_d  = upd_best;
            out_margin_d = margin_w;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          state_d    = COLLECT;
          cnt_d      = '0;
          best_d     = SMIN;
          best_idx_d = '0;
          second_d   = SMIN;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State registers; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= COLLECT;
      cnt_q        <= '0;
      best_q       <= SMIN;
      best_idx_q   <= '0;
      second_q     <= SMIN;
      out_class_q  <= '0;
      out_score_q  <= '0;
      out_margin_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      best_q       <= best_d;
      best_idx_q   <= best_idx_d;
      second_q     <= second_d;
      out_class_q  <= out_class_d;
      out_score_q  <= out_score_d;
      out_margin_q <= out_margin_d;
    end
  end

  assign in_ready   = (state_q == COLLECT);
  assign out_valid  = (state_q == EMIT);
  assign out_class  = out_class_q;
  assign out_score  = out_score_q;
  assign out_margin = out_margin_q;

endmodule

// File: tb/tb_seq_argmax_layer.sv
// Directed and randomized-gap bench for seq_argmax_layer (3 classes, 32-bit, margin 10).
module tb_seq_argmax_layer;

  localparam int NC = 3;
  localparam int DW = 32;
  localparam int RM = 10;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b0;
  logic signed [DW-1:0] in_score = '0;
  logic                 in_ready, out_valid;
  logic [1:0]           out_class;
  logic signed [DW-1:0] out_score;
  logic [DW-1:0]        out_margin;

  int checks = 0;
  int errors = 0;

  seq_argmax_layer #(.NUM_CLASSES(NC), .DATA_W(DW), .REJECT_MARGIN(RM)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_score   (in_score),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_class  (out_class),
    .out_score  (out_score),
    .out_margin (out_margin)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_class(input logic [1:0] idx, input logic [DW-1:0] m);
`ifdef SEQ_ARGMAX_REJECT_EN
    return (m < 32'(RM)) ? 2'd3 : idx;
`else
    return idx;
`endif
  endfunction

  // Drive three beats back to back; the last beat is still pending on return.
  task automatic drive_frame(input logic signed [DW-1:0] a, b, c);
    @(negedge clk); in_valid = 1'b1; in_score = a;
    @(negedge clk); in_score = b;
    @(negedge clk); in_score = c;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Two-pass reference: pick the lowest-index max, then max of the rest.
  task automatic ref_model(input logic signed [DW-1:0] s [3], output logic [1:0] idx,
                           output logic signed [DW-1:0] best, output logic [DW-1:0] margin);
    logic signed [DW-1:0] sec;
    logic signed [DW:0]   d;
    bit                   have;
    idx = 2'd0;
    best = s[0];
    for (int i = 1; i < 3; i++) if (s[i] > best) begin best = s[i]; idx = 2'(i); end
    have = 1'b0;
    sec = '0;
    for (int i = 0; i < 3; i++)
      if (2'(i) != idx && (!have || s[i] > sec)) begin sec = s[i]; have = 1'b1; end
    d = $signed({best[DW-1], best}) - $signed({sec[DW-1], sec});
    margin = d[DW-1:0];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1; in_score = 32'sd123; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_class !== 2'd0) begin errors++; $display("FAIL reset_out_class got %0d want 0", out_class); end
    checks++; if (out_score !== 32'sd0) begin errors++; $display("FAIL reset_out_score got %0d want 0", out_score); end
    checks++; if (out_margin !== 32'd0) begin errors++; $display("FAIL reset_out_margin got %0d want 0", out_margin); end
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_frames();
    logic signed [DW-1:0] sc [4][3];
    logic [1:0]           e_idx [4];
    logic signed [DW-1:0] e_sc [4];
    logic [DW-1:0]        e_m [4];
    sc[0] = '{32'sd500, 32'sd300000, 32'sd2000000}; e_idx[0] = 2'd2; e_sc[0] = 32'sd2000000; e_m[0] = 32'd1700000;
    sc[1] = '{32'sd7, 32'sd7, -32'sd3};             e_idx[1] = 2'd0; e_sc[1] = 32'sd7;       e_m[1] = 32'd0;
    sc[2] = '{-32'sd5, -32'sd2, -32'sd9};           e_idx[2] = 2'd1; e_sc[2] = -32'sd2;      e_m[2] = 32'd3;
    sc[3] = '{32'sd100, 32'sd95, 32'sd0};           e_idx[3] = 2'd0; e_sc[3] = 32'sd100;     e_m[3] = 32'd5;
    for (int f = 0; f < 4; f++) begin
      drive_frame(sc[f][0], sc[f][1], sc[f][2]);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL frame%0d_early_valid got %b want 0", f, out_valid); end
      @(negedge clk); in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL frame%0d_latency got %b want 1", f, out_valid); end
      checks++; if (out_class !== exp_class(e_idx[f], e_m[f])) begin errors++; $display("FAIL frame%0d_class got %0d want %0d", f, out_class, exp_class(e_idx[f], e_m[f])); end
      checks++; if (out_score !== e_sc[f]) begin errors++; $display("FAIL frame%0d_score got %0d want %0d", f, out_score, e_sc[f]); end
      checks++; if (out_margin !== e_m[f]) begin errors++; $display("FAIL frame%0d_margin got %0d want %0d", f, out_margin, e_m[f]); end
      handshake();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL frame%0d_release valid=%b ready=%b want 0/1", f, out_valid, in_ready); end
    end
  endtask

  task automatic test_hold();
    drive_frame(32'sd10, -32'sd20, 32'sd30);
    @(negedge clk); in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_score = 32'sd1000;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL hold%0d_hs valid=%b ready=%b want 1/0", c, out_valid, in_ready); end
      checks++; if (out_class !== 2'd2 || out_score !== 32'sd30 || out_margin !== 32'd20) begin errors++; $display("FAIL hold%0d_data got %0d/%0d/%0d want 2/30/20", c, out_class, out_score, out_margin); end
    end
    in_valid = 1'b0;
    handshake();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_ready_after got %b want 1", in_ready); end
    drive_frame(32'sd1, 32'sd2, 32'sd3);
    @(negedge clk); in_valid = 1'b0;
    checks++; if (out_class !== exp_class(2'd2, 32'd1) || out_score !== 32'sd3 || out_margin !== 32'd1) begin errors++; $display("FAIL hold_next_frame got %0d/%0d/%0d want %0d/3/1", out_class, out_score, out_margin, exp_class(2'd2, 32'd1)); end
    handshake();
  endtask

  task automatic test_reset_midframe();
    @(negedge clk); in_valid = 1'b1; in_score = 32'sd50;
    @(negedge clk); in_score = 32'sd60;
    @(negedge clk); rst = 1'b1; in_score = 32'sd99; out_ready = 1'b1;
    @(negedge clk); rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midrst_state valid=%b ready=%b want 0/1", out_valid, in_ready); end
    drive_frame(32'sd1, 32'sd9, 32'sd4);
    @(negedge clk); in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_valid got %b want 1", out_valid); end
    checks++; if (out_class !== exp_class(2'd1, 32'd5) || out_score !== 32'sd9 || out_margin !== 32'd5) begin errors++; $display("FAIL midrst_result got %0d/%0d/%0d want %0d/9/5", out_class, out_score, out_margin, exp_class(2'd1, 32'd5)); end
    handshake();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_extra%0d got %b want 0", c, out_valid); end
    end
    drive_frame(32'sd3, 32'sd2, 32'sd1);
    @(negedge clk); in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_class !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL emitrst got valid=%b class=%0d ready=%b want 0/0/1", out_valid, out_class, in_ready); end
  endtask

  task automatic test_back_to_back();
    logic signed [DW-1:0] s [3];
    logic [1:0]           e_idx;
    logic signed [DW-1:0] e_best;
    logic [DW-1:0]        e_m;
    out_ready = 1'b1;
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < 3; i++)
        s[i] = (f % 2 == 1) ? $signed($urandom) : ($signed(32'($urandom_range(0, 6))) - 32'sd3);
      ref_model(s, e_idx, e_best, e_m);
      for (int b = 0; b < 3; b++) begin
        repeat ($urandom_range(0, 2)) begin @(negedge clk); in_valid = 1'b0; end
        @(negedge clk);
        for (int t = 0; t < 8 && in_ready !== 1'b1; t++) begin in_valid = 1'b0; @(negedge clk); end
        if (in_ready !== 1'b1) begin checks++; errors++; $display("FAIL b2b%0d_ready_timeout got %b want 1", f, in_ready); end
        in_valid = 1'b1; in_score = s[b];
      end
      @(negedge clk); in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b%0d_valid got %b want 1", f, out_valid); end
      checks++; if (out_class !== exp_class(e_idx, e_m) || out_score !== e_best || out_margin !== e_m) begin errors++; $display("FAIL b2b%0d_result got %0d/%0d/%0d want %0d/%0d/%0d", f, out_class, out_score, out_margin, exp_class(e_idx, e_m), e_best, e_m); end
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frames();
    test_hold();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_argmax_layer.md
SEQ_ARGMAX_LAYER -- requirements
Module: seq_argmax_layer

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 3, number of class scores per frame (at least 2).
REQ-002 SHALL have parameter DATA_W, default 32, signed score width.
REQ-003 SHALL have parameter REJECT_MARGIN, default 0, unsigned minimum winning margin (used only under REQ-024).
REQ-004 SHALL have localparam IDX_W = $clog2(NUM_CLASSES+1), the class index width (2 at default).
REQ-005 SHALL have port clk, input, 1, the single clock; the block SHALL use one clock.
REQ-006 SHALL have port rst, input, 1; reset SHALL be synchronous and active-high.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_score (input, DATA_W, signed) for the score stream, one class per beat, in class-index order.
REQ-008 SHALL have ports out_valid (output, 1) and out_ready (input, 1) for the result handshake.
REQ-009 SHALL have port out_class, output, IDX_W, the winning class index.
REQ-010 SHALL have port out_score, output, DATA_W, signed, the winning score.
REQ-011 SHALL have port out_margin, output, DATA_W, unsigned, the winning score minus the runner-up score.

Function
REQ-012 SHALL implement a two-state FSM: COLLECT and EMIT.
REQ-013 COLLECT: in_ready = 1 and out_valid = 0; a beat is accepted on in_valid && in_ready.
REQ-014 Each accepted beat SHALL increment the beat counter; the counter SHALL wrap to 0 on the NUM_CLASSES-th beat.
REQ-015 Running-best update SHALL use signed compare:
- Beat 0 loads best, with index 0.
- A later beat replaces best only if strictly greater; ties SHALL keep the lowest index.
- Second-best SHALL track the largest non-winning score and SHALL initialise to the most negative DATA_W value.
REQ-016 On the last beat the FSM SHALL move to EMIT; out_valid SHALL rise the next cycle (latency 1 cycle from the last accepted beat).
REQ-017 EMIT: in_ready = 0; the outputs SHALL hold stable until out_valid && out_ready.
REQ-018 On the handshake the FSM SHALL return to COLLECT; in_ready SHALL be 1 the following cycle and the next frame's state SHALL be cleared.
REQ-019 out_margin = best - second; it SHALL be computed in DATA_W+1 bits and is never negative.
REQ-020 in_valid while in EMIT SHALL be ignored (no acceptance, no state change).

Reset
REQ-021 rst SHALL force, on the clock edge:
- state = COLLECT, counter = 0;
- out_valid = 0, out_class = 0, out_score = 0, out_margin = 0;
- in_ready = 1 the cycle after rst deasserts.
REQ-022 rst mid-frame or in EMIT SHALL discard the partial or pending result; no out_valid pulse SHALL result from that frame.
REQ-023 rst SHALL take priority over simultaneous in_valid or out_ready.

Configuration
REQ-024 With macro SEQ_ARGMAX_REJECT_EN defined: if out_margin < REJECT_MARGIN, out_class SHALL be NUM_CLASSES (reject code); out_score and out_margin SHALL be unchanged.
REQ-025 Without SEQ_ARGMAX_REJECT_EN: out_class SHALL always be the argmax index, and REJECT_MARGIN SHALL be unused.

Structure
REQ-026 Package nn_parameters SHALL hold:
- the NUM_CLASSES default (equal to the final-layer output size, 3);
- DATA_W;
- the default REJECT_MARGIN;
- the FSM state enum typedef.
REQ-027 A sub-module argmax_update SHALL be used: combinational, taking (best, best_idx, second, score, idx) and returning the updated triple.

Verification
REQ-028 Scores {500, 300000, 2000000} -> out_class 2, out_score 2000000, out_margin 1700000, out_valid one cycle after beat 2.
REQ-029 Scores {7, 7, -3} -> out_class 0, out_margin 0; scores {-5, -2, -9} -> out_class 1, out_margin 3.
REQ-030 out_ready held low 5 cycles in EMIT -> out_valid and outputs stable and in_ready 0 throughout; in_ready 1 the cycle after the handshake.
REQ-031 rst asserted after beat 1 of a frame, then a full frame {1, 9, 4} -> exactly one result: class 1, margin 5.
REQ-032 REJECT_MARGIN = 10, scores {100, 95, 0} -> out_class 3 with SEQ_ARGMAX_REJECT_EN defined, out_class 0 without; margin 5 in both cases.
REQ-033 Back-to-back frames with out_ready tied high and in_valid gapped randomly -> every frame's result matches the reference model.
